// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
//
// Contents:
//   uart_state_e          receive FSM state encoding (PARITY code always reserved)
//   UART_DATA_W           data byte width
//   UART_CLKS_PER_BIT_DEF default clocks per bit (10 MHz / 9600 baud)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int UART_DATA_W           = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 1042;

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-byte valid/ready handshake bundle
//
// Signals:
//   rx_data  [7:0] received byte, stable while rx_valid
//   rx_valid       holding register has an unread byte
//   rx_ready       consumer accepts on rx_valid && rx_ready
// Modports:
//   master  byte producer (the deframer)
//   slave   byte consumer (peripheral registers)
interface uart_rx_frame_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous single-bit inputs
//
// Parameters:
//   RESET_VAL  value both stages take in reset (idle level of the input)
// Ports:
//   clk     destination clock
//   resetn  synchronous active-low reset
//   d       asynchronous input
//   q       synchronised output, 2 clocks of latency
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive deframer with one-deep valid/ready holding register
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit, 11-bit frame).
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit, 8..65535
// Ports:
//   clk        CPU clock, rising edge
//   reset      synchronous active-low reset
//   UART_RX    asynchronous serial line, idle high
//   rx_if      byte handshake (master): rx_data, rx_valid, rx_ready
//   frame_err  sticky: bad stop bit or parity mismatch
//   overrun    sticky: completed byte dropped while holding register full
//   err_clr    one-cycle pulse clearing both sticky flags
//   busy       FSM not in IDLE
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              UART_RX,
    uart_rx_frame_if.master   rx_if,
    output logic              frame_err,
    output logic              overrun,
    input  logic              err_clr,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .resetn (reset),
        .d      (UART_RX),
        .q      (rx_s)
    );

    uart_state_e            state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [2:0]             bit_idx_q,   bit_idx_d;
    logic [UART_DATA_W-1:0] shift_q,     shift_d;
    logic [UART_DATA_W-1:0] data_q,      data_d;
    logic                   valid_q,     valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;
    logic                   busy_q,      busy_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q,   par_err_d;
`endif

    logic complete;
    logic set_fe;
    logic set_ov;
    logic accept;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif
        complete    = 1'b0;
        set_fe      = 1'b0;
        set_ov      = 1'b0;
        accept      = valid_q && rx_if.rx_ready;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    // Line back high at mid-start-bit means it was a glitch.
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = 1'b0;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    // LSB arrives first, so shift in at the top.
                    shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = '0;
                    // Even parity: data bits plus parity bit XOR to zero.
                    par_err_d = rx_s != (^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    // Leave at mid-stop-bit so a following start edge is not missed.
                    state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                    if (rx_s && !par_err_q) begin
`else
                    if (rx_s) begin
`endif
                        complete = 1'b1;
                    end else begin
                        set_fe = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A read in the same cycle frees the slot for the new byte.
        if (complete) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                set_ov = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        // Set wins over a simultaneous clear.
        frame_err_d = set_fe ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
        overrun_d   = set_ov ? 1'b1 : (err_clr ? 1'b0 : overrun_q);

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard testbench for uart_rx_frame
module tb_uart_rx_frame;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic UART_RX = 1'b1;
    logic err_clr = 1'b0;
    logic frame_err;
    logic overrun;
    logic busy;

    uart_rx_frame_if vif ();

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .UART_RX   (UART_RX),
        .rx_if     (vif),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted byte must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && vif.rx_valid === 1'b1 && vif.rx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", vif.rx_data);
            end else begin
                chk("rx_data", {24'd0, vif.rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        UART_RX = v;
        wait_clks(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_flip);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ par_flip);
`else
        if (par_flip) wait_clks(0);
`endif
        bit_out(stop_v);
        UART_RX = 1'b1;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        wait_clks(1);
        err_clr = 1'b0;
    endtask

    logic [7:0] b81;

    initial begin
        vif.rx_ready = 1'b1;
        wait_clks(3);
        chk("reset_rx_data", {24'd0, vif.rx_data}, 32'h00);
        chk("reset_rx_valid", {31'd0, vif.rx_valid}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        wait_clks(5);

        // Single byte with ready held high.
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(4);
        chk("a5_valid_cleared", {31'd0, vif.rx_valid}, 32'd0);
        chk("a5_frame_err", {31'd0, frame_err}, 32'd0);
        chk("a5_overrun", {31'd0, overrun}, 32'd0);
        chk("a5_rx_data", {24'd0, vif.rx_data}, 32'hA5);

        // Back-to-back with consumer stalled: second byte overruns.
        vif.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clks(4);
        chk("ovr_valid", {31'd0, vif.rx_valid}, 32'd1);
        chk("ovr_rx_data", {24'd0, vif.rx_data}, 32'h3C);
        chk("ovr_overrun", {31'd0, overrun}, 32'd1);
        chk("ovr_frame_err", {31'd0, frame_err}, 32'd0);
        pulse_err_clr();
        wait_clks(1);
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
        chk("ovr_data_kept", {24'd0, vif.rx_data}, 32'h3C);
        exp_q.push_back(8'h3C);
        vif.rx_ready = 1'b1;
        wait_clks(2);
        chk("ovr_valid_drained", {31'd0, vif.rx_valid}, 32'd0);

        // Bad stop bit, then a good frame.
        send_frame(8'h55, 1'b0, 1'b0);
        wait_clks(4);
        chk("fe_frame_err", {31'd0, frame_err}, 32'd1);
        chk("fe_valid", {31'd0, vif.rx_valid}, 32'd0);
        wait_clks(20);
        pulse_err_clr();
        wait_clks(1);
        chk("fe_cleared", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_clks(4);
        chk("0f_frame_err", {31'd0, frame_err}, 32'd0);
        chk("0f_rx_data", {24'd0, vif.rx_data}, 32'h0F);

        // Short low glitch on idle line.
        UART_RX = 1'b0;
        wait_clks(4);
        UART_RX = 1'b1;
        wait_clks(1);
        chk("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_clks(30);
        chk("glitch_busy_low", {31'd0, busy}, 32'd0);
        chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);
        chk("glitch_overrun", {31'd0, overrun}, 32'd0);
        chk("glitch_valid", {31'd0, vif.rx_valid}, 32'd0);

        // Reset during bit 4 of a frame.
        b81 = 8'h81;
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(b81[i]);
        UART_RX = b81[4];
        wait_clks(8);
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        wait_clks(1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, vif.rx_valid}, 32'd0);
        chk("mid_rst_rx_data", {24'd0, vif.rx_data}, 32'h00);
        chk("mid_rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
        UART_RX = 1'b1;
        wait_clks(2);
        reset = 1'b1;
        wait_clks(10);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clks(4);
        chk("81_rx_data", {24'd0, vif.rx_data}, 32'h81);
        chk("81_frame_err", {31'd0, frame_err}, 32'd0);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        wait_clks(4);
        chk("par_ok_frame_err", {31'd0, frame_err}, 32'd0);
        chk("par_ok_rx_data", {24'd0, vif.rx_data}, 32'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(4);
        chk("par_bad_frame_err", {31'd0, frame_err}, 32'd1);
        chk("par_bad_valid", {31'd0, vif.rx_valid}, 32'd0);
`endif

        wait_clks(5);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side UART deframer feeding the processor's peripheral bus. Synchronises the asynchronous `UART_RX` pin into the divided CPU clock domain and validates the start bit, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Presents each byte through a one-deep valid/ready holding register and flags framing and overrun errors. It sits between the board pin and the processor's UART peripheral registers.

## Interface
- `CLKS_PER_BIT`, default 1042, clocks per bit (10 MHz / 9600 baud); legal range 8..65535.
- `clk` input 1: CPU clock (divided clock); all logic on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `UART_RX` input 1: asynchronous serial line, idle high.
- `rx_data` output 8: received byte; stable while `rx_valid`=1.
- `rx_valid` output 1: holding register contains an unread byte.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid`&&`rx_ready`.
- `frame_err` output 1: sticky; stop bit sampled low (or parity mismatch, see Configuration).
- `overrun` output 1: sticky; a completed byte was dropped because the holding register was full.
- `err_clr` input 1: one-cycle pulse clearing `frame_err` and `overrun`.
- `busy` output 1: FSM not in IDLE.

## Operation
- Input path: two-flop synchroniser; the synchronised line `rx_s` resets to 1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: on `rx_s`=0 go to START; bit counter `cnt`=0.
- START: at `cnt`=CLKS_PER_BIT/2-1 (integer division), sample `rx_s`.
  - If 0, go to DATA with `cnt`=0 and bit index 0.
  - If 1, treat as a glitch: return to IDLE with no flag set.
- DATA: at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the shift register MSB (so the LSB arrives first) and reset `cnt`. After bit index 7, go to PARITY or STOP.
- STOP: at `cnt`=CLKS_PER_BIT-1, sample the stop bit and return to IDLE in the same cycle.
  - Stop bit 1: the byte completes.
  - Stop bit 0: set `frame_err` and discard the byte.
  - Because the FSM is back in IDLE at mid-stop-bit, back-to-back frames are received.
- Byte completion: if `rx_valid`=0, or `rx_valid`&&`rx_ready` in the same cycle, load `rx_data` and keep `rx_valid`=1. Otherwise drop the byte, keep the old `rx_data`, and set `overrun`.
- `rx_valid` clears on `rx_valid`&&`rx_ready` when no new byte completes in that cycle.
- Error flags: `err_clr` clears both flags. If a set event and `err_clr` occur in the same cycle, set wins.
- `cnt` width: $clog2(CLKS_PER_BIT). All comparisons are unsigned.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0; FSM in IDLE; synchroniser = 1.
- Reset mid-frame aborts the frame immediately. No flag is set and no partial byte is delivered.
- Synchroniser latency: 2 clocks from pin to `rx_s`.
- `rx_valid` rises 1 clock after the stop-bit sample cycle.
- End-to-end: start edge on the pin to `rx_valid`=1 is 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 clocks (+CLKS_PER_BIT with parity).
- `busy` is high from the cycle after the falling edge on `rx_s` through the stop-sample cycle.
- `rx_ready` is not required to be held. A byte is accepted exactly on the cycle where `rx_valid`&&`rx_ready`.

## Configuration
- `UART_RX_PARITY_EN` defined: a PARITY state follows DATA and samples an even-parity bit.
  - Mismatch sets `frame_err` and discards the byte.
  - The frame is 11 bits.
- Not defined: 8N1 only; the PARITY state and its logic are absent; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (PARITY encoding always reserved).
  - `UART_DATA_W`=8.
  - Default `CLKS_PER_BIT` constant.
- Sub-module `sync_2ff`: two-flop synchroniser with a reset value parameter, reused for other board inputs.
- The FSM, counters and holding register are flat in `uart_rx_frame`.

## Test plan
All scenarios run with CLKS_PER_BIT=16.
- Byte 8'hA5 sent 8N1, `rx_ready`=1 -> `rx_valid` pulses 1 cycle with `rx_data`=8'hA5; no error flags.
- 8'h3C then 8'hC3 back-to-back, `rx_ready`=0 -> `rx_data`=8'h3C held and `overrun`=1. After `err_clr`, `overrun`=0 and `rx_data` is still 8'h3C.
- 8'h55 with stop bit driven 0 -> `frame_err`=1 and `rx_valid` stays 0. The next good frame 8'h0F is delivered.
- Low glitch of 4 clocks on an idle line -> FSM returns to IDLE, `busy` falls, no flags, no `rx_valid`.
- `reset`=0 asserted during bit 4 of a frame -> all outputs at reset values next cycle. A frame of 8'h81 sent after reset release is received correctly.
- With `UART_RX_PARITY_EN`: 8'h07 with parity bit 1 -> received. Same byte with parity bit 0 -> `frame_err`=1, no `rx_valid`.
